// File: rtl/inv_key_schedule_pkg.sv
// Shared types and constants for the AES-128 inverse key schedule.
// Rounds count down from LAST_ROUND to 0.
package inv_key_schedule_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  typedef logic [127:0] key_t;
  typedef logic [31:0]  word_t;
  typedef logic [3:0]   round_t;

  localparam round_t LAST_ROUND = 4'd10;

  // Word 0 sits in the most significant 32 bits of a 128-bit key.
  localparam int WORD_W = 32;
  localparam int W0_LSB = 96;
  localparam int W1_LSB = 64;
  localparam int W2_LSB = 32;
  localparam int W3_LSB = 0;

endpackage

// File: rtl/inv_key_schedule_if.sv
// Request/round-key stream bundle between a key consumer (master)
// and the inverse key schedule (slave).
interface inv_key_schedule_if;
  import inv_key_schedule_pkg::*;

  logic   start;
  key_t   key_in;
  logic   busy;
  key_t   rk_out;
  round_t rk_num;
  logic   rk_valid;
  logic   rk_ready;
  logic   done;

  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_out, rk_num, rk_valid, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_out, rk_num, rk_valid, done
  );

endinterface

// File: rtl/rcon.sv
// AES-128 round constant for round r (1..10), placed in the top byte.
module rcon (
  input  logic [3:0]  r,
  output logic [31:0] rcon_out
);

  logic [7:0] rc;

  always_comb begin
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
  end

  assign rcon_out = {rc, 24'h000000};

endmodule

// File: rtl/subbyte.sv
// AES SubWord: four parallel S-boxes, each computed as GF(2^8) inverse
// followed by the affine transform.
module subbyte (
  input  logic [31:0] sbox_in,
  output logic [31:0] sbox_out
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] p;
    x = a;
    y = b;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Inverse as b^254 = b^2 * b^4 * ... * b^128; maps 0 to 0 as AES requires.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] pw;
    logic [7:0] inv;
    pw  = b;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign sbox_out[gi*8 +: 8] = sbox(sbox_in[gi*8 +: 8]);
  end

endmodule

// File: rtl/inv_key_schedule.sv
// Walks the AES-128 key schedule backwards from the round-10 key,
// emitting one round key per accepted handshake down to round 0.
module inv_key_schedule
  import inv_key_schedule_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  inv_key_schedule_if.slave bus
);

  state_e state_q, state_d;
  key_t   key_q, key_d;
  round_t num_q, num_d;
  logic   done_q, done_d;

  word_t k0, k1, k2, k3;
  word_t p0, p1, p2, p3;
  word_t rot_p3, sub_p3, rcon_w;
  key_t  prev_key;

  // Previous-round key datapath: words 1..3 are pure XOR chains, word 0
  // needs SubWord(RotWord(P3)) and the constant of the current round.
  assign k0     = key_q[W0_LSB +: WORD_W];
  assign k1     = key_q[W1_LSB +: WORD_W];
  assign k2     = key_q[W2_LSB +: WORD_W];
  assign k3     = key_q[W3_LSB +: WORD_W];
  assign p3     = k3 ^ k2;
  assign p2     = k2 ^ k1;
  assign p1     = k1 ^ k0;
  assign rot_p3 = {p3[23:0], p3[31:24]};

  subbyte u_subbyte (
    .sbox_in  (rot_p3),
    .sbox_out (sub_p3)
  );

  rcon u_rcon (
    .r        (num_q),
    .rcon_out (rcon_w)
  );

  always_comb begin
    p0       = k0 ^ sub_p3 ^ rcon_w;
    prev_key = {p0, p1, p2, p3};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      num_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      num_q   <= num_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    num_d   = num_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          key_d   = bus.key_in;
          num_d   = LAST_ROUND;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.rk_ready) begin
          if (num_q != 4'd0) begin
            key_d = prev_key;
            num_d = num_q - 4'd1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state_q == EMIT);
    bus.rk_valid = (state_q == EMIT);
    bus.rk_out   = key_q;
    bus.rk_num   = num_q;
    bus.done     = done_q;
  end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Random-stimulus bench: a forward AES-128 key expansion model supplies
// the round keys the inverse schedule must reproduce in reverse order.
module tb_inv_key_schedule;

  typedef logic [10:0][127:0] rk_set_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] A1_R9    = 128'hac7766f319fadc2128d12941575c006e;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  rk_set_t exp_rk;

  logic [7:0] sbox_tbl [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  inv_key_schedule_if bus ();

  inv_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Forward FIPS-197 key expansion; entry r is round key r.
  function automatic rk_set_t expand(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rk_set_t     res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]}
             ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) res[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called at posedge+1 in IDLE; returns at posedge+1 of the first EMIT cycle.
  task automatic launch(input logic [127:0] k);
    bus.start  = 1'b1;
    bus.key_in = k;
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  // Consumes the sequence held in exp_rk, checking every cycle that rk_valid
  // is high. Optionally pulses start or asserts rst when rk_num reaches a value.
  task automatic drain(input int pct, input int pulse_at, input int rst_at,
                       output int edges);
    int idx    = 10;
    int guard  = 0;
    bit pulsed = 1'b0;
    bit ready;
    edges = 1;
    while (idx >= 0 && guard < 400) begin
      chk("valid", 128'(bus.rk_valid), 128'(1));
      chk("busy", 128'(bus.busy), 128'(1));
      chk("rk_num", 128'(bus.rk_num), 128'(idx));
      chk("rk_out", bus.rk_out, exp_rk[idx]);
      if (idx == rst_at) begin
        rst = 1'b1;
        bus.rk_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_valid", 128'(bus.rk_valid), 128'(0));
        chk("rst_done", 128'(bus.done), 128'(0));
        chk("rst_num", 128'(bus.rk_num), 128'(0));
        chk("rst_out", bus.rk_out, 128'(0));
        return;
      end
      if (idx == pulse_at && !pulsed) begin
        bus.start  = 1'b1;
        bus.key_in = rand_key();
        pulsed     = 1'b1;
      end
      ready = (int'($urandom_range(0, 99)) < pct);
      bus.rk_ready = ready;
      if (ready) $display("rk %0d accepted %h", idx, bus.rk_out);
      @(posedge clk); #1;
      edges++;
      guard++;
      if (pulsed) bus.start = 1'b0;
      if (ready) idx--;
    end
    chk("seq_timeout", 128'(idx + 1), 128'(0));
    chk("done_hi", 128'(bus.done), 128'(1));
    chk("done_valid", 128'(bus.rk_valid), 128'(0));
    chk("done_busy", 128'(bus.busy), 128'(0));
  endtask

  initial begin
    rk_set_t ka;
    rk_set_t kb;
    int      edges;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.key_in = '0;
    bus.rk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 128'(bus.busy), 128'(0));
    chk("reset_valid", 128'(bus.rk_valid), 128'(0));
    chk("reset_done", 128'(bus.done), 128'(0));
    chk("reset_num", 128'(bus.rk_num), 128'(0));
    chk("reset_out", bus.rk_out, 128'(0));

    // FIPS-197 A.1, start in the first cycle after reset release
    rst = 1'b0;
    exp_rk = expand(FIPS_KEY);
    chk("model_r9", exp_rk[9], A1_R9);
    launch(A1_R10);
    chk("a1_r10", bus.rk_out, A1_R10);
    drain(100, -1, -1, edges);
    chk("a1_latency", 128'(edges), 128'(12));
    chk("a1_r0", bus.rk_out, FIPS_KEY);
    @(posedge clk); #1;
    chk("done_pulse", 128'(bus.done), 128'(0));

    // A.1 with backpressure
    launch(A1_R10);
    drain(40, -1, -1, edges);
    @(posedge clk); #1;

    // start pulse mid-sequence is ignored
    exp_rk = expand(rand_key());
    launch(exp_rk[10]);
    drain(70, 5, -1, edges);
    @(posedge clk); #1;

    // reset at rk_num=6, then a clean full sequence
    exp_rk = expand(rand_key());
    launch(exp_rk[10]);
    drain(100, -1, 6, edges);
    exp_rk = expand(rand_key());
    launch(exp_rk[10]);
    drain(100, -1, -1, edges);
    chk("post_rst_latency", 128'(edges), 128'(12));
    @(posedge clk); #1;

    // back-to-back: start held high across done
    ka = expand(rand_key());
    kb = expand(rand_key());
    exp_rk = ka;
    bus.start  = 1'b1;
    bus.key_in = ka[10];
    @(posedge clk); #1;
    bus.key_in = kb[10];
    drain(100, -1, -1, edges);
    exp_rk = kb;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drain(60, -1, -1, edges);
    @(posedge clk); #1;
    chk("b2b_done_pulse", 128'(bus.done), 128'(0));

    // round trip on further random keys
    for (int n = 0; n < 3; n++) begin
      exp_rk = expand(rand_key());
      launch(exp_rk[10]);
      drain(50, -1, -1, edges);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
